ga_sync_irq: RTL and testbench
==============================

Name: ga_sync_irq

Overview:
- Gate Array side of the CRTC video interface.
- Consumes raw HSYNC/VSYNC/DE from the 6845 and produces the monitor-facing delayed, width-limited HSYNC/VSYNC and blanking.
- Runs the 52-line raster interrupt counter with Z80 acknowledge, plus VSYNC resync and RMR reset.
- Latches the pending screen mode at monitor HSYNC start.

Parameters:
- IRQ_LINES, 52, HSYNC falls per raster interrupt.
- HS_DELAY, 2, chars from CRTC HSYNC rise to monitor HSYNC rise.
- HS_WIDTH, 4, maximum monitor HSYNC width in chars.
- VS_DELAY, 2, CRTC HSYNCs from CRTC VSYNC rise to monitor VSYNC rise.
- VS_WIDTH, 4, maximum monitor VSYNC width in lines.

Ports:
- CLOCK  in  1  system clock
- nRESET  in  1  asynchronous active-low reset
- CLKEN  in  1  character-rate enable (1 MHz); all state advances only on CLKEN except nRESET and IRQ_ACK/RMR_RST
- CRTC_HSYNC  in  1  HSYNC from CRTC
- CRTC_VSYNC  in  1  VSYNC from CRTC
- CRTC_DE  in  1  display enable from CRTC
- IRQ_ACK  in  1  one-CLOCK pulse, Z80 interrupt acknowledge
- RMR_RST  in  1  one-CLOCK pulse, RMR write with bit 4 set
- MODE_REQ  in  2  mode from last RMR write
- HSYNC_O  out  1  monitor HSYNC
- VSYNC_O  out  1  monitor VSYNC
- BLANK  out  1  high when border/sync; equals ~CRTC_DE | HSYNC_O | VSYNC_O, registered on CLKEN
- MODE  out  2  active mode
- nINT  out  1  Z80 interrupt request, active low
- IRQ_CNT  out  6  interrupt counter, debug

Behaviour:
Reset values:
- HSYNC_O=0, VSYNC_O=0, BLANK=1, MODE=0, nINT=1, IRQ_CNT=0.
- Internal hs_cnt=0, vs_wait=0, vs_cnt=0.

Edge detection:
- CRTC_HSYNC and CRTC_VSYNC are registered on CLKEN.
- Rise/fall are detected against the registered copy, so there is one char of latency.

HSYNC shaper (states IDLE, DELAY, ACTIVE):
- IDLE: on HSYNC rise, go to DELAY with hs_cnt=1.
- DELAY: hs_cnt increments. When hs_cnt==HS_DELAY, go to ACTIVE, set HSYNC_O=1 and MODE<=MODE_REQ.
- ACTIVE: ends after HS_WIDTH chars, or on the CLKEN where CRTC_HSYNC is low, whichever is first. Then HSYNC_O=0 and state is IDLE.
- CRTC HSYNC falling during DELAY returns to IDLE with no output pulse.
- A new rise while ACTIVE is ignored.

VSYNC shaper:
- On VSYNC rise, arm vs_wait=VS_DELAY.
- Each HSYNC fall decrements vs_wait. On reaching 0, VSYNC_O=1.
- VSYNC_O clears after VS_WIDTH further HSYNC falls, or when CRTC_VSYNC is low at an HSYNC fall.

Interrupt counter (IRQ_CNT, 6-bit):
- On each HSYNC fall, IRQ_CNT increments.
- If the incremented value equals IRQ_LINES, IRQ_CNT=0 and nINT=0.
- VSYNC resync: on the HSYNC fall where vs_wait reaches 0, IRQ_CNT=0. If IRQ_CNT>=32 beforehand, nINT=0. This takes priority over the normal increment on that fall.

IRQ_ACK (any CLOCK, not gated by CLKEN):
- nINT=1 and IRQ_CNT[5]=0.
- If it coincides with a counter update, the update applies first, then bit 5 is cleared. An interrupt raised on the same cycle still is cleared.

RMR_RST (any CLOCK):
- IRQ_CNT=0 and nINT=1.
- Takes priority over IRQ_ACK and over the counter update.

nRESET mid-frame forces all reset values immediately; no pulse is completed.

Optional Feature:
- Macro GA_CSYNC_EN.
- Defined: adds output CSYNC (1 bit) = HSYNC_O XOR VSYNC_O, registered on CLKEN, reset 0. Equalisation behaviour is inverted-line HSYNC during VSYNC.
- Undefined: port absent and no logic generated.

Decomposition:
- Package ga_pkg: IRQ_LINES default, IRQ_RESYNC_THRESH=32, HS/VS default widths, and the hs state enum (IDLE, DELAY, ACTIVE).
- One sub-module, ga_sync_shaper: generic delay-then-width-limited pulse with step enable, trigger, source-level input and DELAY/WIDTH parameters.
  - Instanced twice: H stepped by CLKEN, V stepped by HSYNC fall.

Test Plan:
- CRTC HSYNC 14 chars wide, period 64 chars -> HSYNC_O rises 3 CLKENs after CRTC rise (1 detect + 2 delay), high exactly 4 chars; MODE updates to MODE_REQ=2 at that rise.
- CRTC HSYNC 3 chars wide -> HSYNC_O high 1 char only; width 1 -> no HSYNC_O pulse.
- 52 HSYNC falls from reset, no VSYNC -> nINT low after the 52nd fall, IRQ_CNT=0; IRQ_ACK -> nINT=1 next CLOCK.
- VSYNC rise with IRQ_CNT=40 -> after 2 HSYNC falls IRQ_CNT=0 and nINT=0; repeat with IRQ_CNT=20 -> IRQ_CNT=0 and nINT stays 1; VSYNC_O high 4 lines.
- IRQ_CNT=50, nINT=0, IRQ_ACK and RMR_RST in the same CLOCK -> IRQ_CNT=0, nINT=1; IRQ_ACK alone with IRQ_CNT=45 -> IRQ_CNT=13.
- nRESET asserted mid HSYNC_O and VSYNC_O -> all outputs at reset values asynchronously; first HSYNC after release behaves as in scenario 1.

Source files
------------

// File: rtl/ga_pkg.sv
// Gate Array sync/IRQ shared definitions.
// Defaults for the raster interrupt and sync shapers.
package ga_pkg;

  localparam int IRQ_LINES_DEF     = 52;
  localparam int IRQ_RESYNC_THRESH = 32;
  localparam int HS_DELAY_DEF      = 2;
  localparam int HS_WIDTH_DEF      = 4;
  localparam int VS_DELAY_DEF      = 2;
  localparam int VS_WIDTH_DEF      = 4;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_DELAY  = 2'd1,
    HS_ACTIVE = 2'd2
  } hs_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ga_sync_shaper.sv
// Delay-then-width-limited pulse generator.
// Counts step_i events after trig_i; level_i low cancels or ends the pulse.
module ga_sync_shaper
  import ga_pkg::*;
#(
  parameter int DLY = 2,
  parameter int WID = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic step_i,
  input  logic trig_i,
  input  logic level_i,
  output logic pulse_o,
  output logic start_o
);

  localparam int CW = $clog2(max2(DLY, WID) + 1);

  hs_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arm on trigger, count delay, then bounded active phase
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HS_IDLE: begin
        if (trig_i) begin
          state_d = HS_DELAY;
          cnt_d   = CW'(1);
        end
      end
      HS_DELAY: begin
        if (step_i) begin
          if (!level_i) begin
            state_d = HS_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CW'(DLY)) begin
            state_d = HS_ACTIVE;
            cnt_d   = CW'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HS_ACTIVE: begin
        if (step_i) begin
          if (!level_i || cnt_q == CW'(WID)) begin
            state_d = HS_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = HS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pulse follows state, start marks the step entering ACTIVE
  always_comb begin
    pulse_o = (state_q == HS_ACTIVE);
    start_o = (state_q == HS_DELAY) && step_i && level_i
              && (cnt_q == CW'(DLY));
  end

endmodule

// File: rtl/ga_sync_irq.sv
// Gate Array CRTC sync shaping, blanking, mode latch and raster IRQ.
// Optional GA_CSYNC_EN adds a registered composite sync output CSYNC.
module ga_sync_irq
  import ga_pkg::*;
#(
  parameter int IRQ_LINES = IRQ_LINES_DEF,
  parameter int HS_DELAY  = HS_DELAY_DEF,
  parameter int HS_WIDTH  = HS_WIDTH_DEF,
  parameter int VS_DELAY  = VS_DELAY_DEF,
  parameter int VS_WIDTH  = VS_WIDTH_DEF
) (
  input  logic       CLOCK,
  input  logic       nRESET,
  input  logic       CLKEN,
  input  logic       CRTC_HSYNC,
  input  logic       CRTC_VSYNC,
  input  logic       CRTC_DE,
  input  logic       IRQ_ACK,
  input  logic       RMR_RST,
  input  logic [1:0] MODE_REQ,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       BLANK,
  output logic [1:0] MODE,
  output logic       nINT,
  output logic [5:0] IRQ_CNT
`ifdef GA_CSYNC_EN
  ,
  output logic       CSYNC
`endif
);

  logic       hs_q, vs_q;
  logic       hrise, hfall, vrise;
  logic       hs_start, vs_start;
  logic       blank_q;
  logic [1:0] mode_q;
  logic       nint_q, nint_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] cnt_inc;

  // Registered copies of CRTC syncs for edge detection
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
    end else if (CLKEN) begin
      hs_q <= CRTC_HSYNC;
      vs_q <= CRTC_VSYNC;
    end
  end

  assign hrise = CLKEN & CRTC_HSYNC & ~hs_q;
  assign hfall = CLKEN & ~CRTC_HSYNC & hs_q;
  assign vrise = CLKEN & CRTC_VSYNC & ~vs_q;

  ga_sync_shaper #(
    .DLY (HS_DELAY),
    .WID (HS_WIDTH)
  ) u_hshape (
    .clk_i   (CLOCK),
    .rst_ni  (nRESET),
    .step_i  (CLKEN),
    .trig_i  (hrise),
    .level_i (CRTC_HSYNC),
    .pulse_o (HSYNC_O),
    .start_o (hs_start)
  );

  ga_sync_shaper #(
    .DLY (VS_DELAY),
    .WID (VS_WIDTH)
  ) u_vshape (
    .clk_i   (CLOCK),
    .rst_ni  (nRESET),
    .step_i  (hfall),
    .trig_i  (vrise),
    .level_i (CRTC_VSYNC),
    .pulse_o (VSYNC_O),
    .start_o (vs_start)
  );

  // Blanking and mode latch, advanced on character enable
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      blank_q <= 1'b1;
      mode_q  <= 2'd0;
    end else if (CLKEN) begin
      blank_q <= ~CRTC_DE | HSYNC_O | VSYNC_O;
      if (hs_start) mode_q <= MODE_REQ;
    end
  end

  assign cnt_inc = cnt_q + 6'd1;

  // Counter update: line count/resync, then ack, then RMR reset wins
  always_comb begin
    cnt_d  = cnt_q;
    nint_d = nint_q;
    if (hfall) begin
      if (vs_start) begin
        if (cnt_q >= 6'(IRQ_RESYNC_THRESH)) nint_d = 1'b0;
        cnt_d = 6'd0;
      end else if (cnt_inc == 6'(IRQ_LINES)) begin
        cnt_d  = 6'd0;
        nint_d = 1'b0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
    if (IRQ_ACK) begin
      nint_d   = 1'b1;
      cnt_d[5] = 1'b0;
    end
    if (RMR_RST) begin
      cnt_d  = 6'd0;
      nint_d = 1'b1;
    end
  end

  // Interrupt state registers; ack/reset act on any clock
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      cnt_q  <= 6'd0;
      nint_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      nint_q <= nint_d;
    end
  end

  assign BLANK   = blank_q;
  assign MODE    = mode_q;
  assign nINT    = nint_q;
  assign IRQ_CNT = cnt_q;

`ifdef GA_CSYNC_EN
  logic csync_q;

  // Composite sync, inverted line sync during vertical sync
  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) csync_q <= 1'b0;
    else if (CLKEN) csync_q <= HSYNC_O ^ VSYNC_O;
  end

  assign CSYNC = csync_q;
`endif

endmodule

// File: tb/tb_ga_sync_irq.sv
// Directed testbench for ga_sync_irq.
// Linear steps with hand-computed expectations.
module tb_ga_sync_irq;

  logic       CLOCK = 1'b0;
  logic       nRESET = 1'b0;
  logic       CLKEN = 1'b0;
  logic       CRTC_HSYNC = 1'b0;
  logic       CRTC_VSYNC = 1'b0;
  logic       CRTC_DE = 1'b0;
  logic       IRQ_ACK = 1'b0;
  logic       RMR_RST = 1'b0;
  logic [1:0] MODE_REQ = 2'd0;
  logic       HSYNC_O, VSYNC_O, BLANK, nINT;
  logic [1:0] MODE;
  logic [5:0] IRQ_CNT;
`ifdef GA_CSYNC_EN
  logic       CSYNC;
`endif

  int total = 0;
  int bad   = 0;

  ga_sync_irq dut (
    .CLOCK      (CLOCK),
    .nRESET     (nRESET),
    .CLKEN      (CLKEN),
    .CRTC_HSYNC (CRTC_HSYNC),
    .CRTC_VSYNC (CRTC_VSYNC),
    .CRTC_DE    (CRTC_DE),
    .IRQ_ACK    (IRQ_ACK),
    .RMR_RST    (RMR_RST),
    .MODE_REQ   (MODE_REQ),
    .HSYNC_O    (HSYNC_O),
    .VSYNC_O    (VSYNC_O),
    .BLANK      (BLANK),
    .MODE       (MODE),
    .nINT       (nINT),
    .IRQ_CNT    (IRQ_CNT)
`ifdef GA_CSYNC_EN
    ,
    .CSYNC      (CSYNC)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic en);
    CLKEN = en;
    @(posedge CLOCK);
    #1;
    CLKEN = 1'b0;
  endtask

  task automatic chr();
    tick(1'b1);
    tick(1'b0);
  endtask

  task automatic hpulse(input int n);
    for (int i = 0; i < n; i++) begin
      CRTC_HSYNC = 1'b1;
      chr();
      CRTC_HSYNC = 1'b0;
      chr();
    end
  endtask

  task automatic do_reset();
    nRESET = 1'b0;
    CRTC_HSYNC = 1'b0;
    CRTC_VSYNC = 1'b0;
    IRQ_ACK = 1'b0;
    RMR_RST = 1'b0;
    tick(1'b0);
    tick(1'b0);
    nRESET = 1'b1;
    tick(1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hs"}, 8'(HSYNC_O), 8'd0);
    chk({tag, "_vs"}, 8'(VSYNC_O), 8'd0);
    chk({tag, "_blank"}, 8'(BLANK), 8'd1);
    chk({tag, "_mode"}, 8'(MODE), 8'd0);
    chk({tag, "_nint"}, 8'(nINT), 8'd1);
    chk({tag, "_cnt"}, 8'(IRQ_CNT), 8'd0);
  endtask

  // 14-char CRTC HSYNC, remainder of a 64-char line low
  task automatic hs_line(input logic [1:0] mreq);
    MODE_REQ = mreq;
    CRTC_HSYNC = 1'b1;
    chr();
    chr();
    chk("hs_delay", 8'(HSYNC_O), 8'd0);
    chr();
    chk("hs_rise", 8'(HSYNC_O), 8'd1);
    chk("hs_mode", 8'(MODE), 8'(mreq));
    chr();
    chk("hs_blank", 8'(BLANK), 8'd1);
    chr();
    chr();
    chk("hs_hold", 8'(HSYNC_O), 8'd1);
    chr();
    chk("hs_width", 8'(HSYNC_O), 8'd0);
    for (int i = 0; i < 7; i++) chr();
    CRTC_HSYNC = 1'b0;
    for (int i = 0; i < 50; i++) chr();
  endtask

  logic seen;

  initial begin
    do_reset();
    check_reset_vals("rst");

    CRTC_DE = 1'b1;
    chr();
    chk("blank_de", 8'(BLANK), 8'd0);

    hs_line(2'd2);
    chk("cnt_line1", 8'(IRQ_CNT), 8'd1);

    CRTC_HSYNC = 1'b1;
    chr();
    chr();
    chr();
    chk("hs3_on", 8'(HSYNC_O), 8'd1);
    CRTC_HSYNC = 1'b0;
    chr();
    chk("hs3_off", 8'(HSYNC_O), 8'd0);

    seen = 1'b0;
    CRTC_HSYNC = 1'b1;
    chr();
    seen |= HSYNC_O;
    CRTC_HSYNC = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chr();
      seen |= HSYNC_O;
    end
    chk("hs1_none", 8'(seen), 8'd0);
    chk("cnt_3", 8'(IRQ_CNT), 8'd3);
    CRTC_DE = 1'b0;

    do_reset();
    hpulse(51);
    chk("irq51_cnt", 8'(IRQ_CNT), 8'd51);
    chk("irq51_nint", 8'(nINT), 8'd1);
    hpulse(1);
    chk("irq52_cnt", 8'(IRQ_CNT), 8'd0);
    chk("irq52_nint", 8'(nINT), 8'd0);
    IRQ_ACK = 1'b1;
    tick(1'b0);
    IRQ_ACK = 1'b0;
    chk("ack_nint", 8'(nINT), 8'd1);

    do_reset();
    hpulse(40);
    CRTC_VSYNC = 1'b1;
    chr();
    hpulse(1);
    chk("vs40_wait", 8'(VSYNC_O), 8'd0);
    chk("vs40_cnt1", 8'(IRQ_CNT), 8'd41);
    hpulse(1);
    chk("vs40_cnt", 8'(IRQ_CNT), 8'd0);
    chk("vs40_nint", 8'(nINT), 8'd0);
    chk("vs40_on", 8'(VSYNC_O), 8'd1);
    hpulse(3);
    chk("vs_hold", 8'(VSYNC_O), 8'd1);
    hpulse(1);
    chk("vs_width", 8'(VSYNC_O), 8'd0);
    CRTC_VSYNC = 1'b0;
    chr();

    do_reset();
    hpulse(20);
    CRTC_VSYNC = 1'b1;
    chr();
    hpulse(2);
    chk("vs20_cnt", 8'(IRQ_CNT), 8'd0);
    chk("vs20_nint", 8'(nINT), 8'd1);
    chk("vs20_on", 8'(VSYNC_O), 8'd1);
    CRTC_VSYNC = 1'b0;
    hpulse(1);
    chk("vs20_low", 8'(VSYNC_O), 8'd0);

    do_reset();
    hpulse(102);
    chk("c50_cnt", 8'(IRQ_CNT), 8'd50);
    chk("c50_nint", 8'(nINT), 8'd0);
    IRQ_ACK = 1'b1;
    RMR_RST = 1'b1;
    tick(1'b0);
    IRQ_ACK = 1'b0;
    RMR_RST = 1'b0;
    chk("rmr_cnt", 8'(IRQ_CNT), 8'd0);
    chk("rmr_nint", 8'(nINT), 8'd1);
    hpulse(45);
    IRQ_ACK = 1'b1;
    tick(1'b0);
    IRQ_ACK = 1'b0;
    chk("ack45_cnt", 8'(IRQ_CNT), 8'd13);
    hpulse(38);
    chk("c51_cnt", 8'(IRQ_CNT), 8'd51);
    CRTC_HSYNC = 1'b1;
    chr();
    CRTC_HSYNC = 1'b0;
    IRQ_ACK = 1'b1;
    tick(1'b1);
    IRQ_ACK = 1'b0;
    chk("ackco_cnt", 8'(IRQ_CNT), 8'd0);
    chk("ackco_nint", 8'(nINT), 8'd1);

    do_reset();
    CRTC_VSYNC = 1'b1;
    chr();
    hpulse(2);
    MODE_REQ = 2'd2;
    CRTC_HSYNC = 1'b1;
    chr();
    chr();
    chr();
    chk("mid_hs", 8'(HSYNC_O), 8'd1);
    chk("mid_vs", 8'(VSYNC_O), 8'd1);
    chk("mid_mode", 8'(MODE), 8'd2);
    nRESET = 1'b0;
    #2;
    check_reset_vals("arst");
    CRTC_HSYNC = 1'b0;
    CRTC_VSYNC = 1'b0;
    tick(1'b0);
    nRESET = 1'b1;
    chr();
    chr();
    hs_line(2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
